hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage MIPS core; sits beside the forwarding logic and drives the stall/flush controls of the IF/ID and ID/EX registers. Detects load-use and decode-stage branch-operand hazards, applies taken-branch flushes, and schedules the shared multi-cycle mult/div unit. It sequences a busy counter and stalls dependent HI/LO instructions until the unit completes.

---
 rtl/hazard_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard detection, taken-branch flush and mult/div busy scheduling for the 5-stage core.
// Optional perf counters behind HAZARD_PERF_CNT_EN; hazard outputs are combinational, md_done is registered.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] dec_rs,
  input  logic [4:0] dec_rt,
  input  logic       dec_branch,
  input  logic       dec_pc_src,
  input  logic       dec_muldiv_start,
  input  logic       dec_uses_hilo,
  input  logic [4:0] dec_ex_rt,
  input  logic [4:0] dec_ex_rd,
  input  logic       dec_ex_memread,
  input  logic       dec_ex_regwrite,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_memtoreg,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lw_stall;
  logic             br_stall;
  logic             md_stall;
  logic             stall;

  // Register 0 is hard-wired, so a zero destination never creates a dependency.
  assign lw_stall = dec_ex_memread && (dec_ex_rt != 5'd0) &&
                    ((dec_ex_rt == dec_rs) || (dec_ex_rt == dec_rt));

  assign br_stall = dec_branch &&
                    ((dec_ex_regwrite && (dec_ex_rd != 5'd0) &&
                      ((dec_ex_rd == dec_rs) || (dec_ex_rd == dec_rt))) ||
                     (ex_mem_memtoreg && (ex_mem_rd != 5'd0) &&
                      ((ex_mem_rd == dec_rs) || (ex_mem_rd == dec_rt))));

  assign md_stall = (state == BUSY) && (dec_uses_hilo || dec_muldiv_start);
  assign stall    = !reset && (lw_stall || br_stall || md_stall);

  assign stall_f  = stall;
  assign stall_d  = stall;
  assign flush_e  = reset || stall;
  assign flush_d  = reset || (dec_pc_src && !stall);
  assign md_busy  = !reset && (state == BUSY);
  assign md_start = !reset && (state == IDLE) && dec_muldiv_start && !lw_stall && !br_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state   <= IDLE;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_d) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
